// File: rtl/piso_serializer.sv
// piso_serializer: parallel-in / serial-out stage with valid/ready load handshake.
// Emits one bit per clock with start/end frame strobes and supports back-to-back
// frames. A new word may be accepted during the last-bit cycle of the current frame.
module piso_serializer #(
    parameter int unsigned WIDTH     = 8,
    parameter bit          MSB_FIRST = 1'b1
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic             load_valid,
    output logic             load_ready,
    input  logic [WIDTH-1:0] load_data,
    output logic             serial_out,
    output logic             serial_valid,
    output logic             frame_start,
    output logic             frame_end,
    output logic             busy
);

    if (WIDTH < 2) begin : g_width_check
        $error("piso_serializer: WIDTH must be >= 2");
    end

    localparam int unsigned    CW   = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0]  LAST = CW'(WIDTH - 1);

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } state_t;

    state_t           state, state_d;
    logic [CW-1:0]    count, count_d;
    logic [WIDTH-1:0] sreg, sreg_d;
    logic [WIDTH-1:0] shifted;
    logic             serial_out_d, serial_valid_d, frame_start_d, frame_end_d, busy_d;
    logic             last_bit, accept;

    // State, shift register and registered outputs.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            count        <= '0;
            sreg         <= '0;
            serial_out   <= 1'b0;
            serial_valid <= 1'b0;
            frame_start  <= 1'b0;
            frame_end    <= 1'b0;
            busy         <= 1'b0;
        end else begin
            state        <= state_d;
            count        <= count_d;
            sreg         <= sreg_d;
            serial_out   <= serial_out_d;
            serial_valid <= serial_valid_d;
            frame_start  <= frame_start_d;
            frame_end    <= frame_end_d;
            busy         <= busy_d;
        end
    end

    // Next-state, datapath and handshake decode.
    // serial_out is a separate register holding the bit currently on the wire;
    // the bit that follows is the top (or bottom) of the already-shifted word.
    always_comb begin
        state_d        = state;
        count_d        = count;
        sreg_d         = sreg;
        serial_out_d   = serial_out;
        serial_valid_d = serial_valid;
        frame_start_d  = frame_start;
        frame_end_d    = frame_end;
        busy_d         = busy;

        shifted    = MSB_FIRST ? {sreg[WIDTH-2:0], 1'b0} : {1'b0, sreg[WIDTH-1:1]};
        last_bit   = (state == SHIFT) && (count == LAST);
        load_ready = (state == IDLE) || last_bit;
        accept     = load_valid && load_ready;

        if (accept) begin
            state_d        = SHIFT;
            count_d        = '0;
            sreg_d         = load_data;
            serial_out_d   = MSB_FIRST ? load_data[WIDTH-1] : load_data[0];
            serial_valid_d = 1'b1;
            frame_start_d  = 1'b1;
            frame_end_d    = (WIDTH == 1);
            busy_d         = 1'b1;
        end else if (state == SHIFT) begin
            if (!last_bit) begin
                count_d       = count + 1'b1;
                sreg_d        = shifted;
                serial_out_d  = MSB_FIRST ? shifted[WIDTH-1] : shifted[0];
                frame_start_d = 1'b0;
                frame_end_d   = ((count + 1'b1) == LAST);
            end else begin
                state_d        = IDLE;
                serial_out_d   = 1'b0;
                serial_valid_d = 1'b0;
                frame_start_d  = 1'b0;
                frame_end_d    = 1'b0;
                busy_d         = 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_piso_serializer.sv
// Directed testbench for piso_serializer (WIDTH=8), MSB-first and LSB-first instances.
module tb_piso_serializer;

    logic       clock;
    logic       reset_n;
    logic       load_valid;
    logic [7:0] load_data;
    logic       sel_lsb;

    logic lr_m, so_m, sv_m, fs_m, fe_m, bz_m;
    logic lr_l, so_l, sv_l, fs_l, fe_l, bz_l;
    logic lr, so, sv, fs, fe, bz;

    int checks = 0;
    int errors = 0;

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b1)) u_msb (
        .clock(clock), .reset_n(reset_n), .load_valid(load_valid), .load_ready(lr_m),
        .load_data(load_data), .serial_out(so_m), .serial_valid(sv_m),
        .frame_start(fs_m), .frame_end(fe_m), .busy(bz_m)
    );

    piso_serializer #(.WIDTH(8), .MSB_FIRST(1'b0)) u_lsb (
        .clock(clock), .reset_n(reset_n), .load_valid(load_valid), .load_ready(lr_l),
        .load_data(load_data), .serial_out(so_l), .serial_valid(sv_l),
        .frame_start(fs_l), .frame_end(fe_l), .busy(bz_l)
    );

    assign lr = sel_lsb ? lr_l : lr_m;
    assign so = sel_lsb ? so_l : so_m;
    assign sv = sel_lsb ? sv_l : sv_m;
    assign fs = sel_lsb ? fs_l : fs_m;
    assign fe = sel_lsb ? fe_l : fe_m;
    assign bz = sel_lsb ? bz_l : bz_m;

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_so"}, so, 1'b0);
        check({tag, "_sv"}, sv, 1'b0);
        check({tag, "_fs"}, fs, 1'b0);
        check({tag, "_fe"}, fe, 1'b0);
        check({tag, "_busy"}, bz, 1'b0);
    endtask

    // Runs through the 8 output cycles of a frame whose accept edge is the next posedge.
    // exp_bits lists the wire order with the first bit in position 7.
    // ff_cycle: cycle on which an 8'hFF offer is made (must be ignored), 0 = none.
    // chain: offer chain_data during the last-bit cycle for a back-to-back frame.
    task automatic run_frame(input string tag, input logic [7:0] exp_bits,
                             input int ff_cycle, input logic chain,
                             input logic [7:0] chain_data);
        for (int i = 1; i <= 8; i++) begin
            @(posedge clock);
            #1;
            load_valid = 1'b0;
            if (i == ff_cycle) begin
                load_valid = 1'b1;
                load_data  = 8'hFF;
            end
            if (i == 8 && chain) begin
                load_valid = 1'b1;
                load_data  = chain_data;
            end
            check($sformatf("%s_so_c%0d", tag, i), so, exp_bits[8-i]);
            check($sformatf("%s_sv_c%0d", tag, i), sv, 1'b1);
            check($sformatf("%s_fs_c%0d", tag, i), fs, i == 1);
            check($sformatf("%s_fe_c%0d", tag, i), fe, i == 8);
            check($sformatf("%s_lr_c%0d", tag, i), lr, i == 8);
            check($sformatf("%s_busy_c%0d", tag, i), bz, 1'b1);
        end
    endtask

    task automatic offer(input logic [7:0] d);
        load_valid = 1'b1;
        load_data  = d;
    endtask

    task automatic after_frame_idle(input string tag);
        @(posedge clock);
        #1;
        check_idle(tag);
        check({tag, "_lr"}, lr, 1'b1);
    endtask

    initial begin
        sel_lsb    = 1'b0;
        reset_n    = 1'b0;
        load_valid = 1'b0;
        load_data  = 8'h00;

        // Reset state
        repeat (2) @(posedge clock);
        #1;
        check_idle("rst");
        check("rst_so_lsb", so_l, 1'b0);
        check("rst_sv_lsb", sv_l, 1'b0);
        reset_n = 1'b1;
        #1;
        check("rst_lr", lr, 1'b1);

        // Single MSB-first frame 8'hA5
        @(posedge clock);
        #1;
        offer(8'hA5);
        run_frame("a5", 8'hA5, 0, 1'b0, 8'h00);
        after_frame_idle("a5_end");

        // Back-to-back 8'hA5 then 8'h3C offered in the last-bit cycle
        offer(8'hA5);
        run_frame("b2b1", 8'hA5, 0, 1'b1, 8'h3C);
        run_frame("b2b2", 8'h3C, 0, 1'b0, 8'h00);
        after_frame_idle("b2b_end");

        // Load offered mid-frame is ignored
        offer(8'h96);
        run_frame("ign", 8'h96, 3, 1'b0, 8'h00);
        after_frame_idle("ign_end");
        check("ign_stays_idle_sv", sv, 1'b0);

        // LSB-first instance, 8'h01 -> 1 then seven 0s
        sel_lsb = 1'b1;
        offer(8'h01);
        run_frame("lsb01", 8'b1000_0000, 0, 1'b0, 8'h00);
        after_frame_idle("lsb01_end");
        offer(8'hC4);
        run_frame("lsbc4", 8'b0010_0011, 0, 1'b0, 8'h00);
        after_frame_idle("lsbc4_end");
        sel_lsb = 1'b0;

        // Asynchronous reset after the 4th bit of 8'hA5
        offer(8'hA5);
        for (int i = 1; i <= 4; i++) begin
            @(posedge clock);
            #1;
            load_valid = 1'b0;
        end
        check("mid_so_c4", so, 1'b0);
        check("mid_sv_c4", sv, 1'b1);
        #2;
        reset_n = 1'b0;
        #1;
        check_idle("arst");
        check("arst_sv_lsb", sv_l, 1'b0);
        @(posedge clock);
        #1;
        check_idle("arst_hold");
        reset_n = 1'b1;
        #1;
        check("arst_rel_lr", lr, 1'b1);
        @(posedge clock);
        #1;
        check_idle("arst_rel");
        offer(8'h5A);
        run_frame("p5a", 8'h5A, 0, 1'b0, 8'h00);
        after_frame_idle("p5a_end");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
